// File: rtl/rr_priority_arbiter_if.sv
// rtl/rr_priority_arbiter_if.sv - request/grant bundle between input buffers and the arbiter
//
// Ports (grouped):
//   req          NREQ  request per input buffer, held for the whole packet
//   last         NREQ  final-beat flag, looked at only for the granted requester
//   fixed_mode   1     1 = fixed priority (bit 0 highest), 0 = round-robin
//   grant        NREQ  registered one-hot grant, zero when idle
//   grant_valid  1     registered |grant
//   priority_val NREQ  registered one-hot pointer for the next arbitration
//   contention   1     one-cycle pulse: several requesters competed for this grant
//   timeout      1     one-cycle pulse: grant was cut by the hold counter
// Modports: master = requester side, slave = arbiter side.

interface rr_priority_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] last;
   logic            fixed_mode;
   logic [NREQ-1:0] grant;
   logic            grant_valid;
   logic [NREQ-1:0] priority_val;
   logic            contention;
   logic            timeout;

   modport master (
      output req, last, fixed_mode,
      input  grant, grant_valid, priority_val, contention, timeout
   );

   modport slave (
      input  req, last, fixed_mode,
      output grant, grant_valid, priority_val, contention, timeout
   );
endinterface

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - round-robin / fixed-priority packet arbiter with hold timeout
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      rr_priority_arbiter_if.slave (req/last/fixed_mode in, grant/status out)
// Parameters:
//   NREQ     number of requesters (>= 2)
//   HOLD_MAX longest grant in cycles before forced release; 0 disables the timeout

module rr_priority_arbiter #(
   parameter int NREQ     = 4,
   parameter int HOLD_MAX = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   rr_priority_arbiter_if.slave        bus
);

   localparam int IW          = (NREQ < 2) ? 1 : $clog2(NREQ);
   localparam int CW          = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
   localparam int HOLD_LAST_I = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
   localparam logic [CW-1:0]   HOLD_LAST = HOLD_LAST_I[CW-1:0];
   localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]      state;
   logic [NREQ-1:0] grant_q;
   logic            grant_valid_q;
   logic [NREQ-1:0] priority_q;
   logic            contention_q;
   logic            timeout_q;
   logic [CW-1:0]   hold_cnt;
   logic [IW-1:0]   g_idx;

   logic [IW-1:0]   start_idx;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   next_idx;
   logic            win_found;
   logic            multi_req;
   logic            hold_hit;
   logic            normal_release;

   // Search upward from the start index with wrap; the first set request wins.
   always_comb begin
      start_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (priority_q[i]) start_idx = IW'(i);
      end
      if (bus.fixed_mode) start_idx = '0;

      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int            cand;
         logic [IW-1:0] cand_idx;
         cand = int'(start_idx) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = IW'(cand);
         if (!win_found && bus.req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // More than one bit set iff clearing the lowest set bit leaves something.
   assign multi_req      = (bus.req & (bus.req - ONE_HOT0)) != '0;
   assign next_idx       = (g_idx == IW'(NREQ - 1)) ? '0 : g_idx + IW'(1);
   assign normal_release = !bus.req[g_idx] || bus.last[g_idx];
   assign hold_hit       = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         priority_q    <= ONE_HOT0;
         contention_q  <= 1'b0;
         timeout_q     <= 1'b0;
         hold_cnt      <= '0;
         g_idx         <= '0;
      end else begin
         contention_q <= 1'b0;
         timeout_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant_q       <= ONE_HOT0 << win_idx;
                  grant_valid_q <= 1'b1;
                  contention_q  <= multi_req;
                  hold_cnt      <= '0;
                  g_idx         <= win_idx;
                  state         <= BUSY;
               end
            end
            BUSY: begin
               if (normal_release || hold_hit) begin
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  state         <= IDLE;
                  // Timeout is flagged only when nothing else ended the packet.
                  timeout_q     <= hold_hit && !normal_release;
                  priority_q    <= bus.fixed_mode ? ONE_HOT0 : (ONE_HOT0 << next_idx);
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant        = grant_q;
   assign bus.grant_valid  = grant_valid_q;
   assign bus.priority_val = priority_q;
   assign bus.contention   = contention_q;
   assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - directed scoreboard bench for rr_priority_arbiter

module tb_rr_priority_arbiter;

   typedef struct {
      string      tag;
      logic [3:0] g;
      logic [3:0] g0;
      logic [3:0] pv;
      logic       c;
      logic       t;
   } exp_t;

   exp_t sb[$];

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] last = '0;
   logic       fixed_mode = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rr_priority_arbiter_if #(.NREQ(4)) bus4 ();
   rr_priority_arbiter_if #(.NREQ(4)) bus0 ();

   assign bus4.req        = req;
   assign bus4.last       = last;
   assign bus4.fixed_mode = fixed_mode;
   assign bus0.req        = req;
   assign bus0.last       = last;
   assign bus0.fixed_mode = fixed_mode;

   rr_priority_arbiter #(.NREQ(4), .HOLD_MAX(4)) dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus4.slave)
   );

   rr_priority_arbiter #(.NREQ(4), .HOLD_MAX(0)) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0.slave)
   );

   task automatic chk(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue what must appear after the edge, then check it.
   task automatic step(input string tag, input logic rn, input logic [3:0] r, input logic [3:0] l,
                       input logic fm, input logic [3:0] eg, input logic [3:0] eg0,
                       input logic [3:0] epv, input logic ec, input logic et);
      exp_t e;
      reset_n    = rn;
      req        = r;
      last       = l;
      fixed_mode = fm;
      e.tag = tag; e.g = eg; e.g0 = eg0; e.pv = epv; e.c = ec; e.t = et;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.tag, "grant",        bus4.grant,                 e.g);
      chk(e.tag, "grant_valid",  {3'b0, bus4.grant_valid},   {3'b0, |e.g});
      chk(e.tag, "priority_val", bus4.priority_val,          e.pv);
      chk(e.tag, "contention",   {3'b0, bus4.contention},    {3'b0, e.c});
      chk(e.tag, "timeout",      {3'b0, bus4.timeout},       {3'b0, e.t});
      chk(e.tag, "grant_h0",     bus0.grant,                 e.g0);
   endtask

   initial begin
      // reset
      step("rst0",  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("rst1",  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("idle",  1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 0, 0);

      // single requester, last on third beat
      step("s_a",   1, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0001, 0, 0);
      step("s_b",   1, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0001, 0, 0);
      step("s_c",   1, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0001, 0, 0);
      step("s_rel", 1, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0100, 0, 0);
      step("s_idl", 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0100, 0, 0);

      // round-robin fairness from a fresh pointer
      step("rr_rst", 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("rr_g0", 1, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0);
      step("rr_r0", 1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0);
      step("rr_g1", 1, 4'b1111, 4'b1111, 0, 4'b0010, 4'b0010, 4'b0010, 1, 0);
      step("rr_r1", 1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0100, 0, 0);
      step("rr_g2", 1, 4'b1111, 4'b1111, 0, 4'b0100, 4'b0100, 4'b0100, 1, 0);
      step("rr_r2", 1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 4'b1000, 0, 0);
      step("rr_g3", 1, 4'b1111, 4'b1111, 0, 4'b1000, 4'b1000, 4'b1000, 1, 0);
      step("rr_r3", 1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("rr_g4", 1, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0);
      step("rr_r4", 1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0);
      step("rr_idl", 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0);

      // pointer wrap and skip
      step("w_g2",  1, 4'b0100, 4'b0100, 0, 4'b0100, 4'b0100, 4'b0010, 0, 0);
      step("w_r2",  1, 4'b0100, 4'b0100, 0, 4'b0000, 4'b0000, 4'b1000, 0, 0);
      step("w_g0",  1, 4'b0101, 4'b0101, 0, 4'b0001, 4'b0001, 4'b1000, 1, 0);
      step("w_r0",  1, 4'b0101, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0);
      step("w_g2b", 1, 4'b0101, 4'b0101, 0, 4'b0100, 4'b0100, 4'b0010, 1, 0);
      step("w_r2b", 1, 4'b0101, 4'b0101, 0, 4'b0000, 4'b0000, 4'b1000, 0, 0);
      step("w_idl", 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1000, 0, 0);

      // hold timeout (HOLD_MAX=4) vs no timeout (HOLD_MAX=0)
      step("t_1",   1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b1000, 0, 0);
      step("t_2",   1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b1000, 0, 0);
      step("t_3",   1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b1000, 0, 0);
      step("t_4",   1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b1000, 0, 0);
      step("t_rel", 1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 4'b0010, 0, 1);
      step("t_reg", 1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0010, 0, 0);
      step("t_h1",  1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0010, 0, 0);
      step("t_h2",  1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0010, 0, 0);
      step("t_wd",  1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0);

      // fixed priority: bit 0 always wins, pointer pinned to bit 0
      step("f_g1",  1, 4'b1001, 4'b1001, 1, 4'b0001, 4'b0001, 4'b0010, 1, 0);
      step("f_r1",  1, 4'b1001, 4'b1001, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("f_g2",  1, 4'b1001, 4'b1001, 1, 4'b0001, 4'b0001, 4'b0001, 1, 0);
      step("f_r2",  1, 4'b1001, 4'b1001, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("f_g3",  1, 4'b1001, 4'b1001, 1, 4'b0001, 4'b0001, 4'b0001, 1, 0);
      step("f_r3",  1, 4'b1001, 4'b1001, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("f_idl", 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 0, 0);

      // reset in the middle of a grant
      step("m_g2",  1, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 4'b0001, 0, 0);
      step("m_h",   1, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 4'b0001, 0, 0);
      step("m_rst", 0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
      step("m_g1",  1, 4'b0110, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0001, 1, 0);
      step("m_rel", 1, 4'b0110, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0100, 0, 0);
      step("m_idl", 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0100, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
